// File: rtl/seven_seg_scanner.sv
// Six-digit common-anode seven-segment scanner: snapshots a packed-BCD time once per
// frame and multiplexes it with leading-zero blanking and dash display for non-BCD nibbles.
module seven_seg_scanner #(
    parameter int         REFRESH_DIV = 50000,
    parameter logic [5:0] DP_MASK     = 6'b010100,
    parameter bit         BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] disp_time,
    input  logic        blank,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int            PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(REFRESH_DIV - 1);
    localparam logic [7:0]    DPM  = {2'b00, DP_MASK};

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic [PW-1:0] r_presc_p0;
    logic [2:0]    r_idx_p0;
    logic [23:0]   r_snap_p0;
    logic          r_load_pend_p0;
    logic [5:0]    r_an_p1;
    logic [6:0]    r_seg_p1;
    logic          r_dp_p1;
    logic          r_fd_p1;

    logic          w_term;
    logic          w_wrap;
    logic [3:0]    w_digit;
    logic          w_lead;
    logic          w_dark;
    logic [5:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    // Stage p0 -> p1: decode the active digit of the held snapshot
    always_comb begin
        w_term  = (r_presc_p0 == TERM);
        w_wrap  = w_term && (r_idx_p0 == 3'd5);
        w_digit = r_snap_p0[{r_idx_p0, 2'b00} +: 4];
        // A digit is a leading zero when it and everything above it are zero
        w_lead  = BLANK_LZ && (r_idx_p0 != 3'd0) && ((r_snap_p0 >> {r_idx_p0, 2'b00}) == 24'd0);
        w_dark  = blank || w_lead || r_load_pend_p0;
        w_an    = 6'h3f;
        w_seg   = 7'h7f;
        w_dp    = 1'b1;
        if (!w_dark) begin
            w_an  = ~(6'd1 << r_idx_p0);
            w_seg = f_decode(w_digit);
            w_dp  = ~DPM[r_idx_p0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc_p0     <= '0;
            r_idx_p0       <= 3'd0;
            r_snap_p0      <= 24'd0;
            r_load_pend_p0 <= 1'b1;
            r_an_p1        <= 6'h3f;
            r_seg_p1       <= 7'h7f;
            r_dp_p1        <= 1'b1;
            r_fd_p1        <= 1'b0;
        end else begin
            r_an_p1  <= w_an;
            r_seg_p1 <= w_seg;
            r_dp_p1  <= w_dp;
            // The first post-reset edge only loads; scanning starts on the next one
            if (r_load_pend_p0) begin
                r_snap_p0      <= disp_time;
                r_load_pend_p0 <= 1'b0;
                r_fd_p1        <= 1'b1;
            end else begin
                r_presc_p0 <= w_term ? '0 : r_presc_p0 + 1'b1;
                if (w_term) begin
                    r_idx_p0 <= (r_idx_p0 == 3'd5) ? 3'd0 : r_idx_p0 + 3'd1;
                end
                if (w_wrap) begin
                    r_snap_p0 <= disp_time;
                end
                r_fd_p1 <= w_wrap;
            end
        end
    end

    assign an         = r_an_p1;
    assign seg        = r_seg_p1;
    assign dp         = r_dp_p1;
    assign frame_done = r_fd_p1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: two parameterisations driven by shared stimulus and
// checked every cycle against a frame/slot arithmetic model, plus literal spot checks.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] disp_time = 24'h123456;
    logic        blank = 1'b0;

    logic [5:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, fd_a, fd_b;

    always #5 clk = ~clk;

    seven_seg_scanner #(.REFRESH_DIV(4), .DP_MASK(6'b010100), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .reset(reset), .disp_time(disp_time), .blank(blank),
        .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a));

    seven_seg_scanner #(.REFRESH_DIV(1), .DP_MASK(6'b101010), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .reset(reset), .disp_time(disp_time), .blank(blank),
        .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b));

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    int          rd  [2] = '{4, 1};
    bit          blz [2] = '{1'b1, 1'b0};
    logic [5:0]  dpm [2] = '{6'b010100, 6'b101010};

    int          n_chk = 0;
    int          n_fail = 0;
    int          nn [2];
    logic [23:0] msnap [2];
    logic [14:0] expv [2];
    logic [14:0] got [2];
    bit          mvalid = 1'b0;

    assign got[0] = {an_a, seg_a, dp_a, fd_a};
    assign got[1] = {an_b, seg_b, dp_b, fd_b};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    // What the display shows for slot idx of snapshot s: {an, seg, dp}
    function automatic logic [13:0] f_disp(input logic [23:0] s, input int idx, input logic blk,
                                           input bit lz, input logic [5:0] m);
        logic [5:0] a;
        bit         lead;
        lead = lz && (idx > 0);
        for (int j = idx; j < 6; j++) begin
            if (s[4*j +: 4] != 4'h0) lead = 1'b0;
        end
        if (blk || lead) return {6'h3f, 7'h7f, 1'b1};
        a = 6'h3f;
        a[idx] = 1'b0;
        return {a, SEG_TAB[s[4*idx +: 4]], ~m[idx]};
    endfunction

    // Model: nn counts edges since reset release; edge 1 loads, slots begin on edge 2
    always @(posedge clk) begin : model
        logic        fd;
        logic [13:0] disp;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                nn[k] = 0;
                msnap[k] = 24'd0;
                expv[k] = {6'h3f, 7'h7f, 1'b1, 1'b0};
            end else begin
                nn[k]++;
                fd = (nn[k] == 1) || ((nn[k] - 1) % (6 * rd[k]) == 0);
                if (nn[k] == 1) disp = {6'h3f, 7'h7f, 1'b1};
                else disp = f_disp(msnap[k], ((nn[k] - 2) / rd[k]) % 6, blank, blz[k], dpm[k]);
                expv[k] = {disp, fd};
                if (fd) msnap[k] = disp_time;
            end
        end
        mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("an[%0d]", k),  32'(got[k][14:9]), 32'(expv[k][14:9]));
                check($sformatf("seg[%0d]", k), 32'(got[k][8:2]),  32'(expv[k][8:2]));
                check($sformatf("dp[%0d]", k),  32'(got[k][1]),    32'(expv[k][1]));
                check($sformatf("fd[%0d]", k),  32'(got[k][0]),    32'(expv[k][0]));
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic logic [23:0] rand_time();
        logic [23:0] t;
        int          lz;
        lz = $urandom_range(0, 6);
        t = 24'd0;
        for (int i = 0; i < 6; i++) begin
            if (i >= 6 - lz) t[4*i +: 4] = 4'h0;
            else if ($urandom_range(0, 9) == 0) t[4*i +: 4] = 4'($urandom_range(10, 15));
            else t[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return t;
    endfunction

    initial begin
        step(10);
        check("reset_an", 32'(an_a), 32'h3f);
        check("reset_seg", 32'(seg_a), 32'h7f);
        check("reset_dp", 32'(dp_a), 32'd1);
        check("reset_fd", 32'(fd_a), 32'd0);

        reset = 1'b1;
        step(1);
        check("first_fd", 32'(fd_a), 32'd1);
        check("first_dark", 32'(an_a), 32'h3f);
        step(1);
        check("d0_an", 32'(an_a), 32'b111110);
        check("d0_seg", 32'(seg_a), 32'b0000010);
        check("d0_model", 32'(expv[0][8:2]), 32'b0000010);
        step(8);
        check("d2_an", 32'(an_a), 32'b111011);
        check("d2_seg", 32'(seg_a), 32'b0011001);
        check("d2_dp", 32'(dp_a), 32'd0);
        disp_time = 24'h654321;
        step(4);
        check("d3_old_seg", 32'(seg_a), 32'b0110000);
        step(4);
        check("d4_old_seg", 32'(seg_a), 32'b0100100);
        check("d4_dp", 32'(dp_a), 32'd0);
        step(4);
        check("d5_old_an", 32'(an_a), 32'b011111);
        check("d5_old_seg", 32'(seg_a), 32'b1111001);
        step(3);
        check("frame2_fd", 32'(fd_a), 32'd1);
        check("frame2_model_fd", 32'(expv[0][0]), 32'd1);
        step(1);
        check("f2_d0_seg", 32'(seg_a), 32'b1111001);
        step(12);
        check("f2_d3_an", 32'(an_a), 32'b110111);
        check("f2_d3_seg", 32'(seg_a), 32'b0011001);

        reset = 1'b0;
        disp_time = 24'h000007;
        step(1);
        check("midreset_an", 32'(an_a), 32'h3f);
        check("midreset_seg", 32'(seg_a), 32'h7f);
        check("midreset_fd", 32'(fd_a), 32'd0);
        step(2);
        reset = 1'b1;
        step(1);
        check("rel_fd", 32'(fd_a), 32'd1);
        step(1);
        check("lz_d0_an", 32'(an_a), 32'b111110);
        check("lz_d0_seg", 32'(seg_a), 32'b1111000);
        step(1);
        check("nolz_d1_an", 32'(an_b), 32'b111101);
        check("nolz_d1_seg", 32'(seg_b), 32'b1000000);
        step(3);
        check("lz_d1_an", 32'(an_a), 32'h3f);
        check("lz_d1_seg", 32'(seg_a), 32'h7f);
        disp_time = 24'h12A456;
        step(19);
        check("dash_fd", 32'(fd_a), 32'd1);
        step(13);
        check("dash_an", 32'(an_a), 32'b110111);
        check("dash_seg", 32'(seg_a), 32'b0111111);
        step(4);
        check("dash_d4_an", 32'(an_a), 32'b101111);
        check("dash_d4_seg", 32'(seg_a), 32'b0100100);
        blank = 1'b1;
        step(1);
        check("blank_an", 32'(an_a), 32'h3f);
        step(24);
        blank = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) disp_time = rand_time();
            if ($urandom_range(0, 59) == 0) blank = ~blank;
            if (reset && $urandom_range(0, 499) == 0) reset = 1'b0;
            else if (!reset && $urandom_range(0, 2) == 0) reset = 1'b1;
            step(1);
        end
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Display-side consumer of the timer's 24-bit disp_time bus, which carries six packed BCD digits with digit 0 in [3:0].
- Captures disp_time once per refresh frame, so the display never shows a torn value.
- Time-multiplexes the six digits onto a common-anode seven-segment display.
- Applies leading-zero blanking and shows a dash for any nibble that is not valid BCD.
- Sits between timer and the board's display pins.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is held on the display (must be >= 1).
DP_MASK, 6'b010100, bit i set = decimal point lit on digit i (separators between SS/MM/HH).
BLANK_LZ, 1, 1 = enable leading-zero blanking; 0 = always show all six digits.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
disp_time  input  24  six packed BCD digits from timer; digit i = disp_time[4i+3:4i]
blank  input  1  1 = force display dark; scanning continues
an  output  6  digit anodes, active-low; an[i] drives digit i
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
frame_done  output  1  one-cycle pulse when a new frame snapshot is loaded

Behaviour:
- Reset (reset==0 at a clk edge):
  - Registered outputs: an=6'b111111, seg=7'b1111111, dp=1, frame_done=0.
  - Internal state: prescaler=0, digit index=0, snapshot=0, load_pending=1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On the terminal count, the index advances 0→1→…→5→0.
  - With REFRESH_DIV=1 the index advances every cycle.
- Snapshot:
  - Loaded from disp_time on the first clk edge after reset release (load_pending), and on every 5→0 index wrap.
  - frame_done=1 for exactly that cycle.
  - Changes to disp_time at any other time have no visible effect until the next load.
- Outputs:
  - Registered, one cycle behind (index, snapshot).
  - After reset release, digit 0 appears on an at the 2nd clk edge.
  - Each digit is displayed for exactly REFRESH_DIV cycles; a full frame is 6*REFRESH_DIV cycles.
- Active digit i: an = all ones except an[i]=0; seg = decode(snapshot digit i).
- Decode table (seg {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 4'hA–4'hF = dash 0111111
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i (i=1..5) is blanked if it and every more-significant digit equals 4'h0.
  - Digit 0 is never blanked.
  - Invalid nibbles count as non-zero.
- Blanked digit, or blank==1: an=6'b111111, seg=7'b1111111, dp=1. Prescaler and index keep running.
- dp: 0 when DP_MASK[i]==1 and digit i is displayed (not blanked); otherwise 1.
- Reset mid-frame:
  - Takes priority over everything; outputs take reset values on that edge.
  - After release, scanning restarts at digit 0 with a fresh snapshot.

Test Plan:
1. Reset held low 10 cycles, disp_time=24'h123456 → an=111111, seg=1111111, dp=1, frame_done=0 throughout.
2. REFRESH_DIV=4, disp_time=24'h123456, release reset → frame_done pulses on the 1st edge and then every 24 cycles. an sequence per 4 cycles:
   - 111110 seg=0000010 (6), dp=1
   - 111101 seg=0010010 (5)
   - 111011 seg=0011001 (4), dp=0
   - 110111 seg=0110000 (3)
   - 101111 seg=0100100 (2), dp=0
   - 011111 seg=1111001 (1)
3. disp_time=24'h000007 → digit slots 1–5 show an=111111, seg=1111111; digit 0 shows seg=1111000. With 24'h000000, only digit 0 is lit, seg=1000000. With BLANK_LZ=0, all six digits show 1000000.
4. Change disp_time 24'h123456→24'h654321 during the digit-2 slot → digits 3–5 in the same frame still show 3,2,1; the next frame shows 1,2,3,4,5,6 on digits 0..5.
5. disp_time=24'h12A456 → digit 3 seg=0111111 (dash); digits 4,5 show 2,1 (not blanked). blank=1 for one frame → an=111111 for all 24 cycles, frame_done still pulses.
6. Assert reset during the digit-3 slot → outputs go to reset values on that edge. After release, digit 0 is shown next and frame_done pulses on the first post-release edge.
